// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and sync depth.
// Conversions work on zero-extended 32-bit values, so any pointer width up to 32 can use them.
package fifo_pkg;

  localparam int SYNC_STAGES = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Valid/ready output stream of the FIFO read side.
// The master drives data and valid; the slave returns ready.
interface fifo_rd_ctrl_if #(
  parameter int DATASIZE = 8
);
  logic [DATASIZE-1:0] dout_data;
  logic                dout_valid;
  logic                dout_ready;

  modport master (output dout_data, output dout_valid, input dout_ready);
  modport slave  (input dout_data, input dout_valid, output dout_ready);
endinterface

// File: rtl/sync_2ff.sv
// Purpose: N-bit flop-chain synchroniser for a Gray-coded pointer crossing clock domains.
// Latency: SYNC_STAGES clocks.
// Backpressure: none; samples every clock.
module sync_2ff
  import fifo_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Purpose: read-side controller of the dual-clock FIFO; owns rptr, empty flags and level.
// Latency: pop to dout_valid 1 clk (fall-through) or 2 clks (registered memory).
// Backpressure: dout_ready low stops pops once the output stage is full.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int    DATASIZE     = 8,
  parameter int    ADDRSIZE     = 4,
  parameter string FALLTHROUGH  = "TRUE",
  parameter int    AEMPTY_LEVEL = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rclken,
  input  logic [DATASIZE-1:0] rdata_mem,
  fifo_rd_ctrl_if.master      dout,
  output logic                rempty,
  output logic                arempty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int PW      = ADDRSIZE + 1;
  localparam bit FT_MODE = (FALLTHROUGH == "TRUE");

  logic [PW-1:0]       wq2_gray, wq2_bin;
  logic [PW-1:0]       rbin_q, rbin_d, rptr_gray_q, rlevel_q, rlevel_d;
  logic                rempty_q, rempty_d, arempty_q, arempty_d;
  logic                pop;
  logic [DATASIZE-1:0] dout_q;
  logic                dout_vld_q;

  sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .clk_i  (rclk),
    .rst_ni (rrst_n),
    .d_i    (wptr_gray),
    .q_o    (wq2_gray)
  );

  assign wq2_bin = PW'(gray2bin(32'(wq2_gray)));

  // Flags come from post-pop pointer values, so they settle in the pop cycle itself.
  assign rbin_d    = rbin_q + PW'(pop);
  assign rlevel_d  = wq2_bin - rbin_d;
  assign rempty_d  = (rbin_d == wq2_bin);
  assign arempty_d = (rlevel_d <= PW'(AEMPTY_LEVEL));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      rlevel_q    <= '0;
      rempty_q    <= 1'b1;
      arempty_q   <= 1'b1;
    end else begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= PW'(bin2gray(32'(rbin_d)));
      rlevel_q    <= rlevel_d;
      rempty_q    <= rempty_d;
      arempty_q   <= arempty_d;
    end
  end

  generate
    if (FT_MODE) begin : g_fallthrough
      assign pop = !rempty_q && (!dout_vld_q || dout.dout_ready);

      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
          dout_q     <= '0;
          dout_vld_q <= 1'b0;
        end else if (pop) begin
          dout_q     <= rdata_mem;
          dout_vld_q <= 1'b1;
        end else if (dout.dout_ready) begin
          dout_vld_q <= 1'b0;
        end
      end
    end else begin : g_registered
      logic [DATASIZE-1:0] skid_q;
      logic                skid_vld_q, inflight_q, consume, dout_free;
      logic [2:0]          occ;

      assign consume   = dout_vld_q && dout.dout_ready;
      assign dout_free = !dout_vld_q || consume;
      // Words held or already requested, net of the one leaving this cycle.
      assign occ = 3'(dout_vld_q) + 3'(skid_vld_q) + 3'(inflight_q) - 3'(consume);
      assign pop = !rempty_q && (occ < 3'd2);

      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
          dout_q     <= '0;
          dout_vld_q <= 1'b0;
          skid_q     <= '0;
          skid_vld_q <= 1'b0;
          inflight_q <= 1'b0;
        end else begin
          inflight_q <= pop;
          if (dout_free) begin
            if (skid_vld_q) begin
              dout_q     <= skid_q;
              dout_vld_q <= 1'b1;
              skid_vld_q <= inflight_q;
              if (inflight_q) skid_q <= rdata_mem;
            end else if (inflight_q) begin
              dout_q     <= rdata_mem;
              dout_vld_q <= 1'b1;
            end else begin
              dout_vld_q <= 1'b0;
            end
          end else if (inflight_q) begin
            skid_q     <= rdata_mem;
            skid_vld_q <= 1'b1;
          end
        end
      end
    end
  endgenerate

  assign rclken          = pop;
  assign raddr           = rbin_q[ADDRSIZE-1:0];
  assign rptr_gray       = rptr_gray_q;
  assign rempty          = rempty_q;
  assign arempty         = arempty_q;
  assign rlevel          = rlevel_q;
  assign dout.dout_data  = dout_q;
  assign dout.dout_valid = dout_vld_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: one fall-through and one registered-read instance
// share the write pointer, reset and a behavioural memory.
module tb_fifo_rd_ctrl;

  logic       clk, rst_n;
  logic [4:0] wptr_gray;
  logic [4:0] rptr_ft, rptr_rg, rlevel_ft, rlevel_rg;
  logic [3:0] raddr_ft, raddr_rg;
  logic       rclken_ft, rclken_rg, rempty_ft, rempty_rg, arempty_ft, arempty_rg;
  logic [7:0] rdata_ft, rdata_rg;
  logic [7:0] mem [16];
  int         wcnt, chk, pass;

  fifo_rd_ctrl_if #(.DATASIZE(8)) if_ft ();
  fifo_rd_ctrl_if #(.DATASIZE(8)) if_rg ();

  fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("TRUE"), .AEMPTY_LEVEL(1)) u_ft (
    .rclk(clk), .rrst_n(rst_n), .wptr_gray(wptr_gray), .rptr_gray(rptr_ft),
    .raddr(raddr_ft), .rclken(rclken_ft), .rdata_mem(rdata_ft), .dout(if_ft),
    .rempty(rempty_ft), .arempty(arempty_ft), .rlevel(rlevel_ft)
  );

  fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("FALSE"), .AEMPTY_LEVEL(1)) u_rg (
    .rclk(clk), .rrst_n(rst_n), .wptr_gray(wptr_gray), .rptr_gray(rptr_rg),
    .raddr(raddr_rg), .rclken(rclken_rg), .rdata_mem(rdata_rg), .dout(if_rg),
    .rempty(rempty_rg), .arempty(arempty_rg), .rlevel(rlevel_rg)
  );

  always #5 clk = ~clk;

  assign rdata_ft = mem[raddr_ft];
  always @(posedge clk) if (rclken_rg) rdata_rg <= mem[raddr_rg];

  function automatic logic [7:0] wdat(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  task automatic wr(input logic [7:0] d);
    logic [4:0] wb;
    mem[wcnt % 16] = d;
    wcnt++;
    wb = 5'(wcnt);
    wptr_gray = wb ^ (wb >> 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wcnt = 0;
    wptr_gray = '0;
    if_ft.dout_ready = 1'b0;
    if_rg.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    wr(8'h11);
    @(negedge clk);
    wr(8'h22);
    repeat (8) @(negedge clk);
    chk++; if (if_ft.dout_valid !== 1'b1) $display("FAIL reset_pre_valid_ft: got %b want 1", if_ft.dout_valid); else pass++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    wcnt = 0;
    wptr_gray = '0;
    #1;
    chk++; if (rempty_ft !== 1'b1) $display("FAIL reset_rempty_ft: got %b want 1", rempty_ft); else pass++;
    chk++; if (arempty_ft !== 1'b1) $display("FAIL reset_arempty_ft: got %b want 1", arempty_ft); else pass++;
    chk++; if (rlevel_ft !== 5'd0) $display("FAIL reset_rlevel_ft: got %0d want 0", rlevel_ft); else pass++;
    chk++; if (if_ft.dout_valid !== 1'b0) $display("FAIL reset_valid_ft: got %b want 0", if_ft.dout_valid); else pass++;
    chk++; if (if_ft.dout_data !== 8'h00) $display("FAIL reset_data_ft: got %h want 00", if_ft.dout_data); else pass++;
    chk++; if (rptr_ft !== 5'd0) $display("FAIL reset_rptr_ft: got %h want 0", rptr_ft); else pass++;
    chk++; if (raddr_ft !== 4'd0) $display("FAIL reset_raddr_ft: got %h want 0", raddr_ft); else pass++;
    chk++; if (rclken_ft !== 1'b0) $display("FAIL reset_rclken_ft: got %b want 0", rclken_ft); else pass++;
    chk++; if (rempty_rg !== 1'b1) $display("FAIL reset_rempty_rg: got %b want 1", rempty_rg); else pass++;
    chk++; if (rlevel_rg !== 5'd0) $display("FAIL reset_rlevel_rg: got %0d want 0", rlevel_rg); else pass++;
    chk++; if (if_rg.dout_valid !== 1'b0) $display("FAIL reset_valid_rg: got %b want 0", if_rg.dout_valid); else pass++;
    chk++; if (rptr_rg !== 5'd0) $display("FAIL reset_rptr_rg: got %h want 0", rptr_rg); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    if_ft.dout_ready = 1'b1;
    if_rg.dout_ready = 1'b1;
    mem[0] = 8'hA5;
    wcnt = 1;
    wptr_gray = 5'd1;
    @(negedge clk);
    chk++; if (rempty_ft !== 1'b1) $display("FAIL single_rempty_e1: got %b want 1", rempty_ft); else pass++;
    @(negedge clk);
    chk++; if (rempty_ft !== 1'b1) $display("FAIL single_rempty_e2: got %b want 1", rempty_ft); else pass++;
    // Two synchroniser flops, then the flag register.
    @(negedge clk);
    chk++; if (rempty_ft !== 1'b0) $display("FAIL single_rempty_e3: got %b want 0", rempty_ft); else pass++;
    chk++; if (rlevel_ft !== 5'd1) $display("FAIL single_rlevel: got %0d want 1", rlevel_ft); else pass++;
    chk++; if (rclken_ft !== 1'b1) $display("FAIL single_rclken_on: got %b want 1", rclken_ft); else pass++;
    chk++; if (raddr_ft !== 4'd0) $display("FAIL single_raddr: got %h want 0", raddr_ft); else pass++;
    chk++; if (rclken_rg !== 1'b1) $display("FAIL single_rclken_rg: got %b want 1", rclken_rg); else pass++;
    @(negedge clk);
    chk++; if (rclken_ft !== 1'b0) $display("FAIL single_rclken_off: got %b want 0", rclken_ft); else pass++;
    chk++; if (if_ft.dout_valid !== 1'b1) $display("FAIL single_valid_ft: got %b want 1", if_ft.dout_valid); else pass++;
    chk++; if (if_ft.dout_data !== 8'hA5) $display("FAIL single_data_ft: got %h want a5", if_ft.dout_data); else pass++;
    chk++; if (rempty_ft !== 1'b1) $display("FAIL single_rempty_after: got %b want 1", rempty_ft); else pass++;
    chk++; if (rptr_ft !== 5'd1) $display("FAIL single_rptr: got %h want 1", rptr_ft); else pass++;
    chk++; if (if_rg.dout_valid !== 1'b0) $display("FAIL single_valid_rg_early: got %b want 0", if_rg.dout_valid); else pass++;
    @(negedge clk);
    chk++; if (if_rg.dout_valid !== 1'b1) $display("FAIL single_valid_rg: got %b want 1", if_rg.dout_valid); else pass++;
    chk++; if (if_rg.dout_data !== 8'hA5) $display("FAIL single_data_rg: got %h want a5", if_rg.dout_data); else pass++;
    chk++; if (if_ft.dout_valid !== 1'b0) $display("FAIL single_valid_ft_drop: got %b want 0", if_ft.dout_valid); else pass++;
  endtask

  task automatic test_backpressure();
    int pops_ft, pops_rg;
    pops_ft = 0;
    pops_rg = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i < 3) wr(8'h10 + 8'(i));
      pops_ft += int'(rclken_ft);
      pops_rg += int'(rclken_rg);
      @(negedge clk);
    end
    chk++; if (pops_ft != 1) $display("FAIL bp_pops_ft: got %0d want 1", pops_ft); else pass++;
    chk++; if (rlevel_ft !== 5'd2) $display("FAIL bp_rlevel_ft: got %0d want 2", rlevel_ft); else pass++;
    chk++; if (pops_rg != 2) $display("FAIL bp_pops_rg: got %0d want 2", pops_rg); else pass++;
    chk++; if (rlevel_rg !== 5'd1) $display("FAIL bp_rlevel_rg: got %0d want 1", rlevel_rg); else pass++;
    for (int i = 0; i < 3; i++) begin
      if_ft.dout_ready = 1'b1;
      if_rg.dout_ready = 1'b1;
      chk++; if (if_ft.dout_valid !== 1'b1 || if_ft.dout_data !== 8'h10 + 8'(i))
        $display("FAIL bp_drain_ft[%0d]: got v=%b d=%h want v=1 d=%h", i, if_ft.dout_valid, if_ft.dout_data, 8'h10 + 8'(i));
      else pass++;
      chk++; if (if_rg.dout_valid !== 1'b1 || if_rg.dout_data !== 8'h10 + 8'(i))
        $display("FAIL bp_drain_rg[%0d]: got v=%b d=%h want v=1 d=%h", i, if_rg.dout_valid, if_rg.dout_data, 8'h10 + 8'(i));
      else pass++;
      @(negedge clk);
    end
    chk++; if (if_ft.dout_valid !== 1'b0) $display("FAIL bp_nodup_ft: got %b want 0", if_ft.dout_valid); else pass++;
    chk++; if (if_rg.dout_valid !== 1'b0) $display("FAIL bp_nodup_rg: got %b want 0", if_rg.dout_valid); else pass++;
  endtask

  task automatic test_aempty();
    logic [4:0] exp_lvl [3];
    logic       exp_ae  [3];
    exp_lvl = '{5'd2, 5'd1, 5'd0};
    exp_ae  = '{1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i < 4) wr(8'h40 + 8'(i));
      @(negedge clk);
    end
    chk++; if (rlevel_ft !== 5'd3) $display("FAIL ae_level3: got %0d want 3", rlevel_ft); else pass++;
    chk++; if (arempty_ft !== 1'b0) $display("FAIL ae_flag3: got %b want 0", arempty_ft); else pass++;
    for (int s = 0; s < 3; s++) begin
      if_ft.dout_ready = 1'b1;
      @(negedge clk);
      if_ft.dout_ready = 1'b0;
      chk++; if (rlevel_ft !== exp_lvl[s]) $display("FAIL ae_level[%0d]: got %0d want %0d", s, rlevel_ft, exp_lvl[s]); else pass++;
      chk++; if (arempty_ft !== exp_ae[s]) $display("FAIL ae_flag[%0d]: got %b want %b", s, arempty_ft, exp_ae[s]); else pass++;
    end
  endtask

  task automatic test_wrap();
    int         rx_ft, rx_rg, wraps, togg, viol;
    logic [3:0] pa;
    logic       pm;
    rx_ft = 0; rx_rg = 0; wraps = 0; togg = 0; viol = 0;
    do_reset();
    pa = raddr_ft;
    pm = rptr_ft[4];
    for (int cyc = 0; cyc < 3000 && !(rx_ft == 40 && rx_rg == 40); cyc++) begin
      if (rclken_ft && rempty_ft) viol++;
      if (rclken_rg && rempty_rg) viol++;
      if (pa == 4'd15 && raddr_ft == 4'd0) wraps++;
      pa = raddr_ft;
      if (rptr_ft[4] != pm) togg++;
      pm = rptr_ft[4];
      if_ft.dout_ready = ($urandom_range(0, 3) != 0);
      if_rg.dout_ready = ($urandom_range(0, 3) != 0);
      if (if_ft.dout_valid && if_ft.dout_ready) begin
        chk++; if (if_ft.dout_data !== wdat(rx_ft)) $display("FAIL wrap_data_ft[%0d]: got %h want %h", rx_ft, if_ft.dout_data, wdat(rx_ft)); else pass++;
        rx_ft++;
      end
      if (if_rg.dout_valid && if_rg.dout_ready) begin
        chk++; if (if_rg.dout_data !== wdat(rx_rg)) $display("FAIL wrap_data_rg[%0d]: got %h want %h", rx_rg, if_rg.dout_data, wdat(rx_rg)); else pass++;
        rx_rg++;
      end
      if (wcnt < 40 && (wcnt - rx_ft) < 12 && (wcnt - rx_rg) < 12 && $urandom_range(0, 3) != 0)
        wr(wdat(wcnt));
      @(negedge clk);
    end
    chk++; if (rx_ft != 40) $display("FAIL wrap_count_ft: got %0d want 40", rx_ft); else pass++;
    chk++; if (rx_rg != 40) $display("FAIL wrap_count_rg: got %0d want 40", rx_rg); else pass++;
    chk++; if (wraps != 2) $display("FAIL wrap_raddr: got %0d want 2", wraps); else pass++;
    chk++; if (togg != 2) $display("FAIL wrap_gray_msb: got %0d want 2", togg); else pass++;
    chk++; if (viol != 0) $display("FAIL wrap_pop_empty: got %0d want 0", viol); else pass++;
    if_ft.dout_ready = 1'b0;
    if_rg.dout_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int waited, stale;
    waited = 0;
    stale = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr(8'h70 + 8'(i));
      @(negedge clk);
    end
    while (if_rg.dout_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk++; if (if_rg.dout_valid !== 1'b1) $display("FAIL mid_fill_timeout: got %b want 1", if_rg.dout_valid); else pass++;
    // One word held in dout and one read still in flight from memory.
    #2;
    rst_n = 1'b0;
    wcnt = 0;
    wptr_gray = '0;
    #1;
    chk++; if (if_rg.dout_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", if_rg.dout_valid); else pass++;
    chk++; if (rptr_rg !== 5'd0) $display("FAIL mid_rptr: got %h want 0", rptr_rg); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    if_rg.dout_ready = 1'b1;
    repeat (12) begin
      if (if_rg.dout_valid !== 1'b0) stale++;
      @(negedge clk);
    end
    chk++; if (stale != 0) $display("FAIL mid_stale: got %0d want 0", stale); else pass++;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    wptr_gray = '0;
    wcnt = 0;
    chk = 0;
    pass = 0;
    if_ft.dout_ready = 1'b0;
    if_rg.dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_single();
    test_backpressure();
    test_aempty();
    test_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
